// File: rtl/accum_frame_amisha_pkg.sv
// Shared types and default sizing for the accum_frame_amisha frame accumulator.
package accum_pkg_amisha;

    localparam logic ST_ACC_ENC  = 1'b0;
    localparam logic ST_HOLD_ENC = 1'b1;

    typedef enum logic {
        ACC  = ST_ACC_ENC,
        HOLD = ST_HOLD_ENC
    } state_t;

    localparam int DEF_N     = 4;
    localparam int DEF_HW    = 4;
    localparam int DEF_LEN   = 8;
    localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/accum_frame_amisha_adder.sv
// N-bit ripple-carry adder with carry-out, shared by the accumulator datapath.
module accum_frame_amisha_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[N];

endmodule

// File: rtl/accum_frame_amisha.sv
// Frame accumulator: sums LEN samples into {carry count, low word} and holds the result.
// Optional build macro ACC_SATURATE_EN makes the frame sum saturate instead of wrapping.
module accum_frame_amisha
    import accum_pkg_amisha::*;
#(
    parameter int N     = DEF_N,
    parameter int HW    = DEF_HW,
    parameter int LEN   = DEF_LEN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic          clk_amisha,
    input  logic          reset_amisha,
    input  logic          in_valid_amisha,
    output logic          in_ready_amisha,
    input  logic [N-1:0]  in_data_amisha,
    input  logic          clear_amisha,
    output logic          out_valid_amisha,
    input  logic          out_ready_amisha,
    output logic [N+HW-1:0] out_sum_amisha,
    output logic          out_ovf_amisha
);

    state_t            state_reg, state_next;
    logic [N-1:0]      lo_reg, lo_next;
    logic [HW-1:0]     hi_reg, hi_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ovf_reg, ovf_next;
    logic [N+HW-1:0]   out_sum_reg, out_sum_next;
    logic              out_ovf_reg, out_ovf_next;

    logic [N-1:0]      add_sum;
    logic              add_cout;
    logic              accept;
    logic              wrap;
    logic [N-1:0]      lo_acc;
    logic [HW-1:0]     hi_acc;
    logic              ovf_acc;

    accum_frame_amisha_adder #(.N(N)) u_adder (
        .a    (lo_reg),
        .b    (in_data_amisha),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // A clear discards the pending result, so it is never offered in that cycle.
    assign in_ready_amisha  = (state_reg == ACC) && !reset_amisha && !clear_amisha;
    assign out_valid_amisha = (state_reg == HOLD) && !clear_amisha;
    assign out_sum_amisha   = out_sum_reg;
    assign out_ovf_amisha   = out_ovf_reg;

    assign accept = in_valid_amisha && in_ready_amisha;
    assign wrap   = (hi_reg == {HW{1'b1}}) && add_cout;

    always_comb begin
        ovf_acc = ovf_reg | wrap;
`ifdef ACC_SATURATE_EN
        if (ovf_reg || wrap) begin
            lo_acc = {N{1'b1}};
            hi_acc = {HW{1'b1}};
        end else begin
            lo_acc = add_sum;
            hi_acc = hi_reg + HW'(add_cout);
        end
`else
        lo_acc = add_sum;
        hi_acc = hi_reg + HW'(add_cout);
`endif
    end

    always_comb begin
        state_next   = state_reg;
        lo_next      = lo_reg;
        hi_next      = hi_reg;
        cnt_next     = cnt_reg;
        ovf_next     = ovf_reg;
        out_sum_next = out_sum_reg;
        out_ovf_next = out_ovf_reg;

        if (clear_amisha) begin
            state_next = ACC;
            lo_next    = '0;
            hi_next    = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (accept) begin
                        if (cnt_reg == CNT_W'(LEN - 1)) begin
                            out_sum_next = {hi_acc, lo_acc};
                            out_ovf_next = ovf_acc;
                            state_next   = HOLD;
                            lo_next      = '0;
                            hi_next      = '0;
                            cnt_next     = '0;
                            ovf_next     = 1'b0;
                        end else begin
                            lo_next  = lo_acc;
                            hi_next  = hi_acc;
                            ovf_next = ovf_acc;
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready_amisha) begin
                        state_next = ACC;
                    end
                end
                default: state_next = ACC;
            endcase
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state_reg   <= ACC;
            lo_reg      <= '0;
            hi_reg      <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            out_sum_reg <= '0;
            out_ovf_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lo_reg      <= lo_next;
            hi_reg      <= hi_next;
            cnt_reg     <= cnt_next;
            ovf_reg     <= ovf_next;
            out_sum_reg <= out_sum_next;
            out_ovf_reg <= out_ovf_next;
        end
    end

endmodule

// File: tb/tb_accum_frame_amisha.sv
// Bench for accum_frame_amisha: default instance plus an HW=2 instance fed the same stream.
module tb_accum_frame_amisha;

    localparam int LEN = 8;
    localparam int W1  = 8;
    localparam int W2  = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_ovf;
    logic [7:0] out_sum;
    logic       in_ready2, out_valid2, out_ovf2;
    logic [5:0] out_sum2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    accum_frame_amisha dut (
        .clk_amisha       (clk),
        .reset_amisha     (reset),
        .in_valid_amisha  (in_valid),
        .in_ready_amisha  (in_ready),
        .in_data_amisha   (in_data),
        .clear_amisha     (clear),
        .out_valid_amisha (out_valid),
        .out_ready_amisha (out_ready),
        .out_sum_amisha   (out_sum),
        .out_ovf_amisha   (out_ovf)
    );

    accum_frame_amisha #(.HW(2)) dut2 (
        .clk_amisha       (clk),
        .reset_amisha     (reset),
        .in_valid_amisha  (in_valid),
        .in_ready_amisha  (in_ready2),
        .in_data_amisha   (in_data),
        .clear_amisha     (clear),
        .out_valid_amisha (out_valid2),
        .out_ready_amisha (out_ready),
        .out_sum_amisha   (out_sum2),
        .out_ovf_amisha   (out_ovf2)
    );

    // Reference: a frame result is the plain integer total, wrapped or clipped to the width.
    function automatic int model_sum(input int total, input int w);
`ifdef ACC_SATURATE_EN
        return (total >= (1 << w)) ? (1 << w) - 1 : total;
`else
        return total % (1 << w);
`endif
    endfunction

    function automatic int model_ovf(input int total, input int w);
        return (total >= (1 << w)) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [3:0] d, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample until it is accepted, bounded so the bench cannot hang.
    task automatic feed(input logic [3:0] d, input logic r);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            set_in(1'b1, d, r, 1'b0);
            acc = in_valid && in_ready;
            tick();
            n++;
        end
        check("feed_accept", int'(acc), 1);
    endtask

    task automatic check_frame(input string tag, input int total);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_sum"}, int'(out_sum), model_sum(total, W1));
        check({tag, "_ovf"}, int'(out_ovf), model_ovf(total, W1));
        check({tag, "_sum2"}, int'(out_sum2), model_sum(total, W2));
        check({tag, "_ovf2"}, int'(out_ovf2), model_ovf(total, W2));
        $display("frame %s: sum=%0h ovf=%0b sum2=%0h ovf2=%0b", tag, out_sum, out_ovf, out_sum2, out_ovf2);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_sum"}, int'(out_sum), 0);
        check({tag, "_ovf"}, int'(out_ovf), 0);
        check({tag, "_sum2"}, int'(out_sum2), 0);
    endtask

    initial begin
        int total;
        int k;
        int delivered;
        int cyc;
        int exp_tot[$];
        logic [3:0] cur;
        logic have;
        logic v;
        logic r;
        logic acc;
        logic del;

        // Reset state, in_ready held low even with a sample offered
        set_in(1'b1, 4'h3, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_in_ready", int'(in_ready), 0);
        check_cleared("reset");
        reset = 1'b0;
        set_in(1'b0, 4'bx, 1'b0, 1'b0);
        check("idle_in_ready", int'(in_ready), 1);

        // 1: eight 4'hF back-to-back, downstream always ready
        for (int i = 0; i < LEN; i++) feed(4'hF, 1'b1);
        check("t1_in_ready_hold", int'(in_ready), 0);
        check_frame("t1", 8 * 15);
        set_in(1'b0, 4'bx, 1'b1, 1'b0);
        check("t1_deliver", int'(out_valid && out_ready), 1);
        tick();
        check("t1_valid_drop", int'(out_valid), 0);
        check("t1_in_ready_back", int'(in_ready), 1);

        // 2: backpressure with a held sample that must survive the stall
        for (int i = 1; i <= LEN; i++) feed(4'(i), 1'b0);
        check_frame("t2", 36);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 4'h9, 1'b0, 1'b0);
            check("t2_stall_ready", int'(in_ready), 0);
            tick();
            check("t2_stall_sum", int'(out_sum), 8'h24);
            check("t2_stall_valid", int'(out_valid), 1);
        end
        set_in(1'b1, 4'h9, 1'b1, 1'b0);
        check("t2_release_no_accept", int'(in_valid && in_ready), 0);
        tick();
        feed(4'h9, 1'b1);
        for (int i = 1; i < LEN; i++) feed(4'h0, 1'b1);
        check_frame("t2_held", 9);
        set_in(1'b0, 4'bx, 1'b1, 1'b0);
        tick();

        // 3: abort after three samples; the sample alongside clear is refused
        for (int i = 0; i < 3; i++) feed(4'h5, 1'b1);
        set_in(1'b1, 4'h5, 1'b1, 1'b1);
        check("t3_clear_no_accept", int'(in_valid && in_ready), 0);
        tick();
        set_in(1'b0, 4'bx, 1'b1, 1'b0);
        check("t3_clear_no_valid", int'(out_valid), 0);
        for (int i = 0; i < LEN; i++) feed(4'h1, 1'b0);
        check_frame("t3", 8);

        // 5: reset in HOLD, then reset mid-frame
        reset = 1'b1;
        set_in(1'b0, 4'bx, 1'b0, 1'b0);
        tick();
        check_cleared("t5_hold_rst");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) feed(4'h7, 1'b1);
        reset = 1'b1;
        set_in(1'b0, 4'bx, 1'b1, 1'b0);
        tick();
        check_cleared("t5_mid_rst");
        reset = 1'b0;
        for (int i = 0; i < LEN; i++) feed(4'h2, 1'b1);
        check_frame("t5", 16);
        set_in(1'b0, 4'bx, 1'b1, 1'b0);
        tick();

        // 6: random valid/ready against the integer-total reference
        total = 0;
        k = 0;
        delivered = 0;
        cyc = 0;
        have = 1'b0;
        cur = 4'h0;
        while (delivered < 20 && cyc < 4000) begin
            if (!have) begin
                cur = 4'($urandom_range(0, 15));
                have = 1'b1;
            end
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            set_in(v, v ? cur : 4'bx, r, 1'b0);
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (del) begin
                check("t6_expected_pending", int'(exp_tot.size() > 0), 1);
                if (exp_tot.size() > 0) begin
                    int t;
                    t = exp_tot.pop_front();
                    check("t6_sum", int'(out_sum), model_sum(t, W1));
                    check("t6_ovf", int'(out_ovf), model_ovf(t, W1));
                    check("t6_sum2", int'(out_sum2), model_sum(t, W2));
                    check("t6_ovf2", int'(out_ovf2), model_ovf(t, W2));
                    $display("rand frame %0d: total=%0d sum=%0h sum2=%0h ovf2=%0b", delivered, t, out_sum, out_sum2, out_ovf2);
                end
                delivered++;
            end
            if (acc) begin
                total += int'(cur);
                k++;
                have = 1'b0;
                if (k == LEN) begin
                    exp_tot.push_back(total);
                    total = 0;
                    k = 0;
                end
            end
            tick();
            cyc++;
        end
        check("t6_frames_delivered", delivered, 20);
        check("t6_none_left", exp_tot.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accum_frame_amisha.md
Name: accum_frame_amisha

Overview:
- Sequential accumulator stage wrapped around the team's existing parameterised N-bit carry-out adder.
- Accepts a stream of N-bit samples over a valid/ready handshake and adds each sample to a running N-bit low word through the adder.
- Counts adder carry-outs into an HW-bit high word.
- After LEN samples, presents the (N+HW)-bit frame sum downstream, with a sticky overflow flag, until it is consumed.

Parameters:
N, 4, sample and adder width (passed to the adder's N)
HW, 4, high-word (carry counter) width; result width is N+HW
LEN, 8, samples per frame; legal range 2..2**CNT_W
CNT_W, 4, sample counter width

Ports:
clk_amisha  input  1  clock, all logic on rising edge
reset_amisha  input  1  synchronous, active-high reset
in_valid_amisha  input  1  sample valid
in_ready_amisha  output  1  stage accepting samples
in_data_amisha  input  N  sample
clear_amisha  input  1  synchronous frame abort
out_valid_amisha  output  1  frame result valid
out_ready_amisha  input  1  downstream accepts result
out_sum_amisha  output  N+HW  {high word, low word} frame sum
out_ovf_amisha  output  1  high word overflowed during this frame (sticky per frame)

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clock clk_amisha, reset reset_amisha.
- Reset values:
  - state = ACC; lo, hi, cnt, ovf = 0.
  - out_valid_amisha = 0; out_sum_amisha = 0; out_ovf_amisha = 0.
  - in_ready_amisha = 0 while reset_amisha is high.
- States:
  - ACC: in_ready_amisha = 1, out_valid_amisha = 0.
  - HOLD: in_ready_amisha = 0, out_valid_amisha = 1.
- Datapath:
  - Adder a = lo, b = in_data_amisha.
  - On accept (in_valid & in_ready): lo <= sum; hi <= hi + cout, modulo 2**HW.
  - If hi is all-ones and cout = 1, ovf <= 1.
  - cnt <= cnt + 1.
- ACC -> HOLD: on the accept with cnt == LEN-1.
  - Same edge: out_sum_amisha <= {hi_next, lo_next}; out_ovf_amisha <= ovf_next.
  - Working registers lo, hi, cnt, ovf are cleared.
  - Latency: last sample accepted at edge k gives out_valid_amisha high after edge k.
- HOLD:
  - out_sum_amisha and out_ovf_amisha are stable while out_ready_amisha is low.
  - On out_ready_amisha = 1, the next edge returns to ACC and drops out_valid_amisha.
  - out_sum_amisha retains its value until overwritten.
- Throughput: LEN+1 cycles per frame when both sides stream.
- in_valid_amisha in HOLD is ignored; upstream must hold the sample.
- clear_amisha priority: below reset, above every handshake.
  - Forces ACC and zeroes lo, hi, cnt, ovf, out_valid_amisha.
  - Any pending result is discarded.
  - A sample presented in the same cycle is not accepted; in_ready_amisha reads 0 while clear_amisha is high.
- Reset mid-frame or in HOLD: all partial and pending data is lost; there is no partial-frame output.
- in_data_amisha is sampled only on accept; X on an idle bus is tolerated.

Optional Feature:
- ACC_SATURATE_EN defined:
  - When the high word would wrap, {hi, lo} saturates to all-ones for the remainder of the frame; further samples are still accepted and counted.
  - ovf is set.
- ACC_SATURATE_EN undefined: high word wraps modulo 2**HW; ovf is still set.

Decomposition:
- Shared package accum_pkg_amisha holds:
  - state enum (ACC, HOLD), encoded as a 1-bit localparam pair;
  - default N, HW, LEN, CNT_W constants.
- One sub-module: the existing N-bit carry-out adder, instantiated with N.
- Counter, FSM and output register stay in the top module.

Test Plan:
1. Defaults. 8 samples of 4'hF streamed back-to-back, out_ready held 1 -> out_valid one cycle after the 8th accept; out_sum = 8'h78, ovf = 0; in_ready returns 1 two cycles after the 8th accept.
2. Backpressure. Frame of samples 1..8 with out_ready low for 5 cycles -> out_sum = 8'h24 stable throughout, in_ready = 0, in_valid ignored, no sample lost after release.
3. clear_amisha after 3 samples of 4'h5, then 8 samples of 4'h1 -> out_sum = 8'h08, ovf = 0; the aborted partial sum is never output.
4. HW = 2 override, 8 samples of 4'hF:
   - without ACC_SATURATE_EN -> out_sum = 6'h38, ovf = 1;
   - with ACC_SATURATE_EN -> out_sum = 6'h3F, ovf = 1.
5. reset_amisha pulsed in HOLD and again after 4 accepted samples -> the cycle after each: out_valid = 0, out_sum = 0, out_ovf = 0; a subsequent full frame of 4'h2 yields 8'h10.
6. Random valid/ready toggling for 20 frames against a reference model -> every out_sum/out_ovf matches the model, and no result is duplicated or dropped.
